// File: rtl/i2c_pkg.sv
// Shared types for the single-byte I2C master: FSM states, quarter phases and bus-drive decode.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP, DONE
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;

  localparam int unsigned BIT_CNT_W = 3;

  // Returns {scl_low, sda_low} for the bus while in state st, quarter ph.
  function automatic logic [1:0] bus_drive(state_t st, phase_t ph, logic data_bit);
    logic scl_low;
    logic sda_low;
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (st)
      START: begin
        sda_low = (ph == Q2) || (ph == Q3);
        scl_low = (ph == Q3);
      end
      STOP: begin
        sda_low = (ph != Q3);
        scl_low = (ph == Q0);
      end
      ADDR, WDATA: begin
        sda_low = ~data_bit;
        scl_low = (ph == Q0) || (ph == Q3);
      end
      AACK, WACK, RDATA, MNACK: scl_low = (ph == Q0) || (ph == Q3);
      default: ;
    endcase
    return {scl_low, sda_low};
  endfunction

endpackage

// File: rtl/i2c_master_clk_gen.sv
// Quarter-period tick divider: one tick every CLK_DIV clks, with synchronous clear and freeze.
module i2c_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = !clear && !freeze && (cnt == CNT_MAX);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, addr+R/W, one data byte, STOP, then done/ack_err/rdata.
// Define I2C_MASTER_STRETCH_EN to honour slave clock stretching at each q1.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  state_t               state, state_n;
  phase_t               phase, phase_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [7:0]           shreg, shreg_n;
  logic [7:0]           wdata_q, wdata_n;
  logic                 rw_q, rw_n;
  logic [7:0]           rdata_n;
  logic                 ack_err_n;
  logic                 scl_low, scl_low_n;
  logic                 sda_low, sda_low_n;
  logic                 tick, freeze, sda_in;

  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign scl    = scl_low ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

`ifdef I2C_MASTER_STRETCH_EN
  assign freeze = busy && (phase == Q1) && (scl == 1'b0);
`else
  assign freeze = 1'b0;
`endif

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .freeze (freeze),
    .tick   (tick)
  );

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    wdata_n   = wdata_q;
    rw_n      = rw_q;
    rdata_n   = rdata;
    ack_err_n = ack_err;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          state_n   = START;
          phase_n   = Q0;
          bit_cnt_n = '0;
          shreg_n   = {addr, rw};
          wdata_n   = wdata;
          rw_n      = rw;
          ack_err_n = 1'b0;
        end
      end
      default: if (tick) begin
        phase_n = phase_t'(phase + 2'd1);
        // ACK bits share the shift register, so the ACK/NACK lands in shreg[0]
        if (phase == Q2 && (state == AACK || state == WACK || state == RDATA))
          shreg_n = {shreg[6:0], sda_in};
        if (phase == Q3) begin
          case (state)
            START: begin
              state_n   = ADDR;
              bit_cnt_n = '0;
            end
            ADDR, WDATA: begin
              shreg_n   = {shreg[6:0], 1'b0};
              bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
              if (bit_cnt == '1) state_n = (state == ADDR) ? AACK : WACK;
            end
            AACK: begin
              if (shreg[0]) begin
                ack_err_n = 1'b1;
                state_n   = STOP;
              end else if (rw_q) begin
                state_n = RDATA;
              end else begin
                state_n = WDATA;
                shreg_n = wdata_q;
              end
            end
            WACK: begin
              ack_err_n = shreg[0];
              state_n   = STOP;
            end
            RDATA: begin
              bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
              if (bit_cnt == '1) state_n = MNACK;
            end
            MNACK: begin
              rdata_n = shreg;
              state_n = STOP;
            end
            STOP:    state_n = DONE;
            default: state_n = IDLE;
          endcase
        end
      end
    endcase
    // Bus levels follow the next state so scl/sda change exactly on the tick edge.
    {scl_low_n, sda_low_n} = bus_drive(state_n, phase_n, shreg_n[7]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= Q0;
      bit_cnt <= '0;
      shreg   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata   <= '0;
      ack_err <= 1'b0;
      scl_low <= 1'b0;
      sda_low <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      wdata_q <= wdata_n;
      rw_q    <= rw_n;
      rdata   <= rdata_n;
      ack_err <= ack_err_n;
      scl_low <= scl_low_n;
      sda_low <= sda_low_n;
    end
  end

endmodule
